// File: rtl/cell_pkg.sv
// Shared definitions for the Sudoku cell command interface: command codes,
// driver FSM state encoding and command classification.
package cell_pkg;

  // Write-only commands (no cell response expected)
  localparam logic [3:0] CMD_NOP           = 4'h0;
  localparam logic [3:0] CMD_LOAD_VALUE    = 4'h1;
  localparam logic [3:0] CMD_CLR_CAND      = 4'h2;
  localparam logic [3:0] CMD_SET_POS_X     = 4'h3;
  localparam logic [3:0] CMD_SET_POS_Y     = 4'h4;
  localparam logic [3:0] CMD_CELL_RESET    = 4'h5;

  // Read commands (exactly one cell response expected)
  localparam logic [3:0] CMD_READ_VALUE    = 4'h8;
  localparam logic [3:0] CMD_READ_CAND_CNT = 4'h9;
  localparam logic [3:0] CMD_READ_SOLVED   = 4'hA;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_RSP = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  // Upper half of the code space is the read class
  function automatic logic is_read_cmd(input logic [3:0] cmd);
    return cmd[3];
  endfunction

endpackage

// File: rtl/cell_cmd_driver.sv
// Host-to-cell command initiator. Accepts one host command at a time, strobes
// it into a single cell, and for read commands waits (with a timeout) for the
// cell's response before returning a one-cycle response pulse to the host.
module cell_cmd_driver
  import cell_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       rst,
  // Host side
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_cmd,
  input  logic [3:0] req_data,
  output logic       rsp_valid,
  output logic [3:0] rsp_data,
  output logic       rsp_timeout,
  output logic       err_spurious,
  // Cell side
  output logic [3:0] cell_cmd,
  output logic [3:0] cell_data_in,
  output logic       cell_data_in_rdy,
  input  logic [3:0] cell_data_out,
  input  logic       cell_data_out_valid
);

  // Counter value seen in the final wait cycle
  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_req_ready;
  logic             r_rsp_valid;
  logic [3:0]       r_rsp_data;
  logic             r_rsp_timeout;
  logic             r_err_spurious;
  logic [3:0]       r_cell_cmd;
  logic [3:0]       r_cell_data_in;
  logic             r_cell_data_in_rdy;

  // A cell response is only expected while waiting; anything else is an error
  logic w_spurious;
  assign w_spurious = cell_data_out_valid && (r_state != ST_WAIT_RSP);

  // Command FSM with all host/cell outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state            <= ST_IDLE;
      r_cnt              <= '0;
      r_req_ready        <= 1'b1;
      r_rsp_valid        <= 1'b0;
      r_rsp_data         <= 4'h0;
      r_rsp_timeout      <= 1'b0;
      r_err_spurious     <= 1'b0;
      r_cell_cmd         <= CMD_NOP;
      r_cell_data_in     <= 4'h0;
      r_cell_data_in_rdy <= 1'b0;
    end else begin
      // Strobes default low; they are raised for a single cycle below
      r_cell_data_in_rdy <= 1'b0;
      r_rsp_valid        <= 1'b0;

      if (w_spurious) begin
        r_err_spurious <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            // The cell-side registers double as the command latch
            r_cell_cmd         <= req_cmd;
            r_cell_data_in     <= req_data;
            r_cell_data_in_rdy <= 1'b1;
            r_req_ready        <= 1'b0;
            r_state            <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          if (is_read_cmd(r_cell_cmd)) begin
            r_cnt   <= '0;
            r_state <= ST_WAIT_RSP;
          end else begin
            r_rsp_valid   <= 1'b1;
            r_rsp_data    <= 4'h0;
            r_rsp_timeout <= 1'b0;
            r_state       <= ST_DONE;
          end
        end

        ST_WAIT_RSP: begin
          // A valid in the last wait cycle takes priority over the timeout
          if (cell_data_out_valid) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_data    <= cell_data_out;
            r_rsp_timeout <= 1'b0;
            r_state       <= ST_DONE;
          end else if (r_cnt == LP_CNT_LAST) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_data    <= 4'h0;
            r_rsp_timeout <= 1'b1;
            r_state       <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_DONE: begin
          r_req_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready        = r_req_ready;
  assign rsp_valid        = r_rsp_valid;
  assign rsp_data         = r_rsp_data;
  assign rsp_timeout      = r_rsp_timeout;
  assign err_spurious     = r_err_spurious;
  assign cell_cmd         = r_cell_cmd;
  assign cell_data_in     = r_cell_data_in;
  assign cell_data_in_rdy = r_cell_data_in_rdy;

endmodule

// File: doc/cell_cmd_driver.md
Name: cell_cmd_driver

Overview:
- Initiator at the far end of the cell command interface: accepts one host command at a time and drives a single Sudoku cell's cmd/data_in/data_in_rdy.
- Collects the cell's data_out/data_out_valid response and returns it to the host, with a timeout.
- Sits between the board-level solver controller and each cell instance. One driver per cell, or one driver muxed across cells by the controller.

Parameters:
- TIMEOUT_CYCLES, 16, cycles spent waiting for cell_data_out_valid before the response is declared timed out; legal range 1..255.
- CNT_W, 8, width of the timeout counter; must satisfy 2**CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  host has a command.
- req_ready  out  1  driver can accept a command (high only in IDLE).
- req_cmd  in  4  command code.
- req_data  in  4  command operand.
- rsp_valid  out  1  one-cycle pulse; response/ack is valid.
- rsp_data  out  4  response data; 0 for write-only acks and timeouts.
- rsp_timeout  out  1  qualifies rsp_valid; cell did not answer in time.
- err_spurious  out  1  sticky; set when cell_data_out_valid is seen outside WAIT_RSP. Cleared only by rst.
- cell_cmd  out  4  command to cell.
- cell_data_in  out  4  operand to cell.
- cell_data_in_rdy  out  1  one-cycle strobe qualifying cell_cmd/cell_data_in.
- cell_data_out  in  4  cell response data.
- cell_data_out_valid  in  1  cell response qualifier.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, timeout counter=0.
  - req_ready=1 once rst deasserts.
  - rsp_valid=0, rsp_data=0, rsp_timeout=0, err_spurious=0.
  - cell_cmd=0 (NOP), cell_data_in=0, cell_data_in_rdy=0.
  - Reset mid-operation abandons the command; no response is produced for it.
- Command classes: codes 0x0-0x7 are write-only (no cell response expected); codes 0x8-0xF are read commands (exactly one cell response expected).
- FSM states: IDLE, ISSUE, WAIT_RSP, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid, in cycle N: latch cmd/data and go to ISSUE.
- ISSUE, cycle N+1:
  - cell_data_in_rdy=1 for exactly this cycle; cell_cmd/cell_data_in hold the latched values.
  - Write-only command: go to DONE with rsp_data=0, rsp_timeout=0.
  - Read command: clear the counter and go to WAIT_RSP.
- WAIT_RSP, from cycle N+2:
  - If cell_data_out_valid: capture cell_data_out and go to DONE with rsp_timeout=0.
  - Otherwise increment the counter.
  - If there is no valid and counter==TIMEOUT_CYCLES-1: go to DONE with rsp_data=0, rsp_timeout=1.
  - A valid arriving in the final wait cycle wins over the timeout.
- DONE:
  - rsp_valid=1 for one cycle, then go to IDLE.
  - There is no host backpressure on rsp.
- Latency:
  - Write ack: rsp_valid at N+2.
  - Read response: cell valid at cycle M (M>=N+2) gives rsp_valid at M+1.
  - Timeout: rsp_valid at N+2+TIMEOUT_CYCLES.
- Back-to-back: the next command is accepted in the cycle after DONE. Minimum command spacing is 3 cycles (write) or 4 (read).
- Outside the strobe cycle: cell_cmd/cell_data_in hold their last values; cell_data_in_rdy=0.
- cell_data_out_valid in IDLE, ISSUE or DONE sets err_spurious and its data is discarded. This includes a valid in the same cycle as the ISSUE strobe.
- A second valid after a response has been captured (in DONE) also sets err_spurious.

Decomposition:
- Shared package cell_pkg holds:
  - command code constants: CMD_NOP=0, CMD_LOAD_VALUE=1, CMD_CLR_CAND=2, CMD_SET_POS_X=3, CMD_SET_POS_Y=4, CMD_CELL_RESET=5, CMD_READ_VALUE=8, CMD_READ_CAND_CNT=9, CMD_READ_SOLVED=10;
  - the 2-bit state enum;
  - a function is_read_cmd(cmd)=cmd[3].
- The cell module also uses cell_pkg.
- No sub-module is needed; the timeout counter stays inline.

Test Plan:
- Reset, then a write: req CMD_LOAD_VALUE data=5 accepted at cycle 0 -> cell_data_in_rdy=1 with cell_cmd=1, cell_data_in=5 at cycle 1; rsp_valid=1, rsp_data=0, rsp_timeout=0 at cycle 2; req_ready=1 at cycle 3.
- Read with response: req CMD_READ_VALUE at cycle 0; cell returns valid with data=7 at cycle 4 -> rsp_valid=1, rsp_data=7 at cycle 5; err_spurious=0.
- Timeout, TIMEOUT_CYCLES=16: req 0x9 at cycle 0 with no cell valid -> rsp_valid=1, rsp_timeout=1, rsp_data=0 at cycle 18.
- Boundary: cell valid with data=3 in the last wait cycle (cycle 17) -> rsp at cycle 18 with rsp_timeout=0, rsp_data=3.
- Spurious: cell_data_out_valid pulsed in IDLE -> err_spurious=1 and it stays 1 across later commands until rst.
- Reset mid-operation: assert rst in WAIT_RSP -> all outputs go to reset values immediately; no rsp_valid is produced for the abandoned command; a new command is accepted normally afterwards.
